m68xx_bus_arbiter: RTL

//  Shares one 8-bit-data SRAM port (tkgate RAM primitive: A, D, active-low WE/OE/CS) between the m6800 CPU
//  and one DMA requester. Per-access REQ/ACK handshake with programmable wait states. Drives the CPU _HALT
//  pin while the DMA owns the bus. Sits between m6800 and _GGRAM in the system netlist.

---
 rtl/m68xx_bus_arbiter_pkg.sv | 23 ++
 rtl/m68xx_wait_timer.sv | 29 ++
 rtl/m68xx_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/m68xx_bus_arbiter_pkg.sv
// Shared encodings and defaults for the m6800 SRAM bus arbiter.
package m68xx_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam int DEF_WAIT    = 2;
  localparam int DEF_DMA_MAX = 4;

  // Fewer than two strobe cycles would leave no room for the write-recovery cycle.
  function automatic int eff_wait(input int w);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/m68xx_wait_timer.sv
// Loadable down-counter with zero flag; a load value of 0 is clamped to 1.
module m68xx_wait_timer #(
  parameter int CW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_load_val == '0) ? CW'(1) : i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/m68xx_bus_arbiter.sv
// Shares one SRAM port between the m6800 CPU and a DMA requester: WAIT strobe cycles, one-cycle ACK, _HALT while DMA owns.
// Define M68XX_ARB_STATS_EN to add saturating per-owner grant counters (CPU_GRANTS / DMA_GRANTS).
module m68xx_bus_arbiter
  import m68xx_bus_arbiter_pkg::*;
#(
  parameter int AW      = 8,
  parameter int WAIT    = DEF_WAIT,
  parameter int DMA_MAX = DEF_DMA_MAX
) (
  input  logic          CLK_1,
  input  logic          RESET,
  input  logic          CPU_REQ,
  input  logic          CPU_RW,
  input  logic [15:0]   CPU_A,
  input  logic [7:0]    CPU_DO,
  output logic [7:0]    CPU_DI,
  output logic          CPU_ACK,
  input  logic          DMA_REQ,
  input  logic          DMA_RW,
  input  logic [15:0]   DMA_A,
  input  logic [7:0]    DMA_DO,
  output logic [7:0]    DMA_DI,
  output logic          DMA_ACK,
  output logic [AW-1:0] RAM_A,
  output logic [7:0]    RAM_DW,
  input  logic [7:0]    RAM_DR,
  output logic          RAM_CS_N,
  output logic          RAM_OE_N,
  output logic          RAM_WE_N,
  output logic          _HALT
`ifdef M68XX_ARB_STATS_EN
  ,
  output logic [15:0]   CPU_GRANTS,
  output logic [15:0]   DMA_GRANTS
`endif
);

  localparam int WAIT_EFF = eff_wait(WAIT);
  localparam int CW       = $clog2(WAIT_EFF + 1);
  localparam int RUNW     = (DMA_MAX < 1) ? 1 : $clog2(DMA_MAX + 1);

  state_e          r_state;
  owner_e          r_owner;
  owner_e          r_last_owner;
  logic            r_rw;
  logic [RUNW-1:0] r_dma_run;

  logic            w_req_any;
  logic            w_grant_dma;
  logic            w_grant_rw;
  logic [CW-1:0]   w_cnt;
  logic            w_zero;

  wire w_unused = &{1'b0, CPU_A[15:AW], DMA_A[15:AW]};

  assign w_req_any = CPU_REQ | DMA_REQ;

  // On a tie the DMA wins only if the CPU went last and the DMA has not used up its run.
  always_comb begin
    w_grant_dma = 1'b0;
    if (DMA_REQ && !CPU_REQ) begin
      w_grant_dma = 1'b1;
    end else if (DMA_REQ && CPU_REQ) begin
      w_grant_dma = (r_last_owner == OWN_CPU) && (r_dma_run != RUNW'(DMA_MAX));
    end
  end

  assign w_grant_rw = w_grant_dma ? DMA_RW : CPU_RW;

  m68xx_wait_timer #(.CW(CW)) u_wait_timer (
    .i_clk      (CLK_1),
    .i_rst      (RESET),
    .i_load     ((r_state == IDLE) && w_req_any),
    .i_load_val (CW'(WAIT_EFF - 1)),
    .i_dec      (r_state == ACCESS),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_ff @(posedge CLK_1) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_rw         <= 1'b1;
      r_dma_run    <= '0;
      RAM_CS_N     <= 1'b1;
      RAM_OE_N     <= 1'b1;
      RAM_WE_N     <= 1'b1;
      RAM_A        <= '0;
      RAM_DW       <= '0;
      CPU_ACK      <= 1'b0;
      DMA_ACK      <= 1'b0;
      CPU_DI       <= '0;
      DMA_DI       <= '0;
      _HALT        <= 1'b1;
    end else begin
      CPU_ACK <= 1'b0;
      DMA_ACK <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_owner  <= w_grant_dma ? OWN_DMA : OWN_CPU;
            r_rw     <= w_grant_rw;
            RAM_A    <= w_grant_dma ? DMA_A[AW-1:0] : CPU_A[AW-1:0];
            RAM_DW   <= w_grant_dma ? DMA_DO : CPU_DO;
            RAM_CS_N <= 1'b0;
            RAM_OE_N <= ~w_grant_rw;
            RAM_WE_N <= w_grant_rw;
            _HALT    <= ~w_grant_dma;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          // WE rises one cycle early so address and data outlast it.
          if (w_cnt == CW'(1)) begin
            RAM_WE_N <= 1'b1;
          end
          if (w_zero) begin
            RAM_CS_N <= 1'b1;
            RAM_OE_N <= 1'b1;
            RAM_WE_N <= 1'b1;
            if (r_owner == OWN_DMA) begin
              DMA_ACK <= 1'b1;
              if (r_rw) DMA_DI <= RAM_DR;
            end else begin
              CPU_ACK <= 1'b1;
              if (r_rw) CPU_DI <= RAM_DR;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_last_owner <= r_owner;
          if (r_owner == OWN_DMA) begin
            if (r_dma_run != RUNW'(DMA_MAX)) r_dma_run <= r_dma_run + 1'b1;
          end else begin
            r_dma_run <= '0;
          end
          _HALT   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef M68XX_ARB_STATS_EN
  always_ff @(posedge CLK_1) begin
    if (RESET) begin
      CPU_GRANTS <= '0;
      DMA_GRANTS <= '0;
    end else if (r_state == DONE) begin
      if (r_owner == OWN_CPU) begin
        if (CPU_GRANTS != 16'hFFFF) CPU_GRANTS <= CPU_GRANTS + 16'd1;
      end else begin
        if (DMA_GRANTS != 16'hFFFF) DMA_GRANTS <= DMA_GRANTS + 16'd1;
      end
    end
  end
`endif

endmodule
